// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
   localparam logic [3:0]  HALT_OPC_DEFAULT = 4'hF;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] pc_plus2;
      logic        valid;
   } ifid_t;

   // 16-bit ripple-carry adder; carry out of bit 15 is dropped so sums wrap.
   function automatic logic [15:0] rca16(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] s;
      logic        c;
      s = '0;
      c = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      return s;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;

   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry skid register holding one fetched word and its address.
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_drain,
   input  logic        i_clear,
   input  logic [15:0] i_instr,
   input  logic [15:0] i_pc,
   output logic        o_valid,
   output logic [15:0] o_instr,
   output logic [15:0] o_pc
);

   logic        r_valid;
   logic [15:0] r_instr;
   logic [15:0] r_pc;

   // Clear wins over load, load wins over drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, fills IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [3:0]  HALT_OPC = HALT_OPC_DEFAULT
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   pc_new,
   input  logic          pc_redirect,
   input  logic          stall_id,
   fetch_stage_if.master imem,
   output logic [15:0]   pc_current,
   output logic          ifid_valid,
   output logic [15:0]   ifid_instr,
   output logic [15:0]   ifid_pc,
   output logic [15:0]   ifid_pc_plus2,
   output logic          halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]   perf_fetched,
   output logic [15:0]   perf_bubbles
`endif
);

   fetch_state_e r_state, w_state_nxt;
   logic [15:0]  r_pc, w_pc_nxt;
   ifid_t        r_ifid, w_ifid_nxt;
   logic         r_halted, w_halted_nxt;
   logic [15:0]  r_drain_addr, w_drain_addr_nxt;

   logic         w_hb_load, w_hb_drain, w_hb_clear;
   logic         w_hb_valid;
   logic [15:0]  w_hb_instr, w_hb_pc;
   logic [15:0]  w_pc_plus2, w_hb_pc_plus2;
   logic         w_can_accept;
   logic         w_ifid_load;

   assign w_pc_plus2    = rca16(r_pc, 16'd2);
   assign w_hb_pc_plus2 = rca16(w_hb_pc, 16'd2);
   assign w_can_accept  = !r_ifid.valid || !stall_id;

   fetch_hold_buf u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_hb_load),
      .i_drain (w_hb_drain),
      .i_clear (w_hb_clear),
      .i_instr (imem.imem_rdata),
      .i_pc    (r_pc),
      .o_valid (w_hb_valid),
      .o_instr (w_hb_instr),
      .o_pc    (w_hb_pc)
   );

   // State, PC and IF/ID registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_ifid       <= '0;
         r_halted     <= 1'b0;
         r_drain_addr <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_ifid       <= w_ifid_nxt;
         r_halted     <= w_halted_nxt;
         r_drain_addr <= w_drain_addr_nxt;
      end
   end

   // Next-state, PC update and IF/ID load; redirect overrides everything.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_ifid_nxt       = r_ifid;
      w_halted_nxt     = r_halted;
      w_drain_addr_nxt = r_drain_addr;
      w_hb_load        = 1'b0;
      w_hb_drain       = 1'b0;
      w_hb_clear       = 1'b0;
      w_ifid_load      = 1'b0;

      // ID consuming the current entry empties IF/ID unless a load below refills it.
      if (r_ifid.valid && !stall_id) begin
         w_ifid_nxt.valid = 1'b0;
      end

      if (pc_redirect) begin
         w_ifid_nxt.valid = 1'b0;
         w_hb_clear       = 1'b0 | 1'b1;
         w_halted_nxt     = 1'b0;
         w_pc_nxt         = pc_new & 16'hFFFE;
         unique case (r_state)
            FETCH: begin
               if (!imem.imem_ready) begin
                  w_state_nxt      = DRAIN;
                  w_drain_addr_nxt = r_pc;
               end else begin
                  w_state_nxt = FETCH;
               end
            end
            // Still waiting on the old request: keep draining, address unchanged.
            DRAIN:   w_state_nxt = imem.imem_ready ? FETCH : DRAIN;
            default: w_state_nxt = FETCH;
         endcase
      end else begin
         unique case (r_state)
            FETCH: begin
               if (imem.imem_ready) begin
                  w_pc_nxt = w_pc_plus2;
                  if (w_can_accept) begin
                     w_ifid_nxt.instr    = imem.imem_rdata;
                     w_ifid_nxt.pc       = r_pc;
                     w_ifid_nxt.pc_plus2 = w_pc_plus2;
                     w_ifid_nxt.valid    = 1'b1;
                     w_ifid_load         = 1'b1;
                     if (imem.imem_rdata[15:12] == HALT_OPC) begin
                        w_state_nxt  = HALTED;
                        w_halted_nxt = 1'b1;
                     end
                  end else begin
                     w_hb_load   = 1'b1;
                     w_state_nxt = HOLD;
                  end
               end
            end
            HOLD: begin
               if (w_hb_valid && w_can_accept) begin
                  w_ifid_nxt.instr    = w_hb_instr;
                  w_ifid_nxt.pc       = w_hb_pc;
                  w_ifid_nxt.pc_plus2 = w_hb_pc_plus2;
                  w_ifid_nxt.valid    = 1'b1;
                  w_ifid_load         = 1'b1;
                  w_hb_drain          = 1'b1;
                  if (w_hb_instr[15:12] == HALT_OPC) begin
                     w_state_nxt  = HALTED;
                     w_halted_nxt = 1'b1;
                  end else begin
                     w_state_nxt = FETCH;
                  end
               end
            end
            DRAIN: begin
               if (imem.imem_ready) begin
                  w_state_nxt = FETCH;
               end
            end
            HALTED: begin
               w_state_nxt = HALTED;
            end
         endcase
      end
   end

   // Memory request: held off during reset; DRAIN keeps presenting the old address.
   always_comb begin
      imem.imem_req  = rst_n && ((r_state == FETCH) || (r_state == DRAIN));
      imem.imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;
   end

   assign pc_current    = r_pc;
   assign ifid_valid    = r_ifid.valid;
   assign ifid_instr    = r_ifid.instr;
   assign ifid_pc       = r_ifid.pc;
   assign ifid_pc_plus2 = r_ifid.pc_plus2;
   assign halted        = r_halted;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_perf_fetched;
   logic [15:0] r_perf_bubbles;

   // Saturating counts of IF/ID loads and empty, non-halted cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= '0;
         r_perf_bubbles <= '0;
      end else begin
         if (w_ifid_load && (r_perf_fetched != '1)) begin
            r_perf_fetched <= r_perf_fetched + 16'd1;
         end
         if (!r_ifid.valid && !r_halted && (r_perf_bubbles != '1)) begin
            r_perf_bubbles <= r_perf_bubbles + 16'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the PC control logic. It owns the PC register and drives pc_current into PC control. It fetches from instruction memory over a req/ready handshake and captures the result in the IF/ID pipeline register. Redirects come from PC control through pc_redirect/pc_new, and the halt opcode freezes fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OPC, 4'hF, opcode (instr[15:12]) that stops fetch.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
pc_new  input  16  redirect target from PC control
pc_redirect  input  1  taken branch/jump resolved downstream; flush and load pc_new
stall_id  input  1  ID cannot accept; hold IF/ID
imem_req  output  1  fetch request
imem_addr  output  16  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  input  1  response valid this cycle (zero-wait allowed)
imem_rdata  input  16  instruction word, sampled when imem_ready=1
pc_current  output  16  PC register; feeds PC control
ifid_valid  output  1  IF/ID holds a live instruction
ifid_instr  output  16  IF/ID instruction
ifid_pc  output  16  address of ifid_instr
ifid_pc_plus2  output  16  ifid_pc+2, mod 2^16
halted  output  1  fetch stopped on HALT_OPC

Behaviour:
- Reset (async on rst_n low): state=FETCH, pc_current=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus2=0, halted=0, hold buffer empty.
- imem_req is forced to 0 while rst_n=0. The first request is issued in the first cycle after deassertion.
- States:
  - FETCH: imem_req=1, imem_addr=pc_current.
  - HOLD: response buffered because IF/ID is stalled; imem_req=0.
  - DRAIN: an outstanding request is being discarded after a redirect; imem_req=1, address held at the old PC.
  - HALTED: imem_req=0.
- IF/ID "can accept" = !ifid_valid || !stall_id.
- FETCH, imem_ready=1, can accept: IF/ID <= {rdata, pc_current, pc_current+2}, ifid_valid=1, pc_current += 2. Throughput is 1 instruction/cycle with zero-wait memory. If rdata[15:12]==HALT_OPC: state=HALTED, halted=1, pc_current=halt addr+2.
- FETCH, imem_ready=1, cannot accept: capture into hold buffer, pc_current += 2, state=HOLD.
- HOLD, stall_id drops: hold moves to IF/ID and state=FETCH, or HALTED if the held word is halt. Instructions are never lost or duplicated.
- Stall with no response: IF/ID is unchanged and the request continues.
- When IF/ID is consumed (ifid_valid && !stall_id) with no new load, ifid_valid <= 0.
- pc_redirect=1 has priority over stall, halt and hold:
  - ifid_valid <= 0, hold buffer cleared, halted <= 0, pc_current <= pc_new.
  - If a request is outstanding (FETCH with imem_ready=0), state=DRAIN. Otherwise state=FETCH.
  - Redirect together with imem_ready in the same cycle: the response is discarded and the next cycle requests pc_new.
- DRAIN: on imem_ready, discard data and go to FETCH. A second redirect in DRAIN only updates pc_current.
- HALTED exits only on pc_redirect (an older branch in ID overrides the halt) or reset.
- All PC arithmetic is 16-bit unsigned and wraps: 16'hFFFE+2 = 16'h0000.
- pc_redirect with odd pc_new: bit 0 is forced to 0.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[15:0] (instructions loaded into IF/ID) and perf_bubbles[15:0] (cycles with ifid_valid=0 while not halted). Both are saturating at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - state enum {FETCH, HOLD, DRAIN, HALTED}
  - constants HALT_OPC and RESET_PC defaults
  - typedef ifid_t {instr, pc, pc_plus2, valid}
- One sub-module, fetch_hold_buf: a single-entry skid register with load/drain/clear, reused for the hold path.
- PC increment uses the existing 16-bit ripple-carry adder.

Test Plan:
- Zero-wait, imem_ready=1, mem[a]=a|16'h1000 -> ifid_pc 0x0000, 0x0002, 0x0004 on consecutive cycles; ifid_instr 0x1000, 0x1002, 0x1004.
- Three wait states on the first fetch -> imem_addr stays 0x0000 for 3 cycles; ifid_valid=1 the cycle after imem_ready, with ifid_pc_plus2=0x0002.
- stall_id=1 for 4 cycles while the response for 0x0004 arrives -> state HOLD, imem_req=0; after release ifid_pc=0x0004 exactly once, then 0x0006.
- pc_redirect with pc_new=0x0040 during a wait state -> DRAIN; the old response is discarded; next request is addr 0x0040; ifid_valid=0 until it returns.
- mem[0x0006]=0xF000 -> halted=1, imem_req=0, pc_current=0x0008 held for 10 cycles; then pc_redirect to 0x0100 -> halted=0 and the fetch of 0x0100 resumes.
- rst_n pulsed low mid-wait -> outputs immediately at reset values; pc_current=0x0000; first request after release has imem_addr=0x0000.
